// File: rtl/alu_pkg.sv
// Shared types for the ALU scheduler: opcode and FSM state enums plus the
// opcode legality check used to raise rsp_err.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_MUL = 4'b0000,
        OP_MOD = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_DIV = 4'b0110,
        OP_SHR = 4'b1000,
        OP_ADD = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] sel);
        logic legal;
        case (sel)
            OP_MUL, OP_MOD, OP_AND, OP_OR,
            OP_XOR, OP_DIV, OP_SHR, OP_ADD: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Shared combinational ALU. Operands are zero-extended to the 2N-bit result.
// Carry and overflow only carry meaning for add (N-bit unsigned carry-out and
// N-bit two's-complement overflow); every other opcode reports them as 0.
// Divide/modulo by zero return all-ones and A respectively.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    input  logic [3:0]     sel_i,
    output logic [2*N-1:0] result_o,
    output logic           neg_o,
    output logic           zero_o,
    output logic           cry_o,
    output logic           of_o
);

    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] b_ext;
    logic [N:0]     sum;
    logic           b_zero;

    // Opcode decode and flag generation.
    always_comb begin
        a_ext    = {{N{1'b0}}, a_i};
        b_ext    = {{N{1'b0}}, b_i};
        sum      = {1'b0, a_i} + {1'b0, b_i};
        b_zero   = (b_i == '0);
        result_o = '0;
        cry_o    = 1'b0;
        of_o     = 1'b0;
        case (sel_i)
            OP_MUL: result_o = a_ext * b_ext;
            OP_MOD: result_o = b_zero ? a_ext : (a_ext % b_ext);
            OP_AND: result_o = a_ext & b_ext;
            OP_OR:  result_o = a_ext | b_ext;
            OP_XOR: result_o = a_ext ^ b_ext;
            OP_DIV: result_o = b_zero ? '1 : (a_ext / b_ext);
            OP_SHR: result_o = a_ext >> b_i;
            OP_ADD: begin
                result_o = {{(N-1){1'b0}}, sum};
                cry_o    = sum[N];
                of_o     = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            default: result_o = '0;
        endcase
        neg_o  = result_o[2*N-1];
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter. A single requester is granted regardless of
// the pointer; with both requesting, the pointer index wins. Every grant is
// an acceptance (ready follows grant), so the pointer moves to the other
// index on every grant.
module alu_rr_arb (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // One-hot grant and pointer advance.
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester front end for one shared ALU.
// Optional feature: define ALU_DIVZERO_TRAP_EN to turn div-by-zero into an
// error response (rsp_err=1, rsp_zero=1, result 0) instead of raw ALU output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrate requesters, capture operands/opcode/id on accept
// EXEC  | ALU driven from captured registers; result registered on exit
// RESP  | rsp_valid high, rsp_* held until rsp_ready
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [N-1:0]   req_a0,
    input  logic [N-1:0]   req_b0,
    input  logic [3:0]     req_sel0,
    input  logic [N-1:0]   req_a1,
    input  logic [N-1:0]   req_b1,
    input  logic [3:0]     req_sel1,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*N-1:0] rsp_result,
    output logic           rsp_neg,
    output logic           rsp_zero,
    output logic           rsp_cry,
    output logic           rsp_of,
    output logic           rsp_err,
    output logic           busy
);

    state_e         state_q;
    state_e         state_d;
    logic [1:0]     gnt;
    logic           arb_en;
    logic           accept;

    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [3:0]     sel_q;
    logic           id_q;

    logic [2*N-1:0] alu_result;
    logic           alu_neg;
    logic           alu_zero;
    logic           alu_cry;
    logic           alu_of;

    logic [2*N-1:0] result_d;
    logic           neg_d;
    logic           zero_d;
    logic           cry_d;
    logic           of_d;
    logic           err_d;

    logic [2*N-1:0] result_q;
    logic           neg_q;
    logic           zero_q;
    logic           cry_q;
    logic           of_q;
    logic           err_q;
    logic           rsp_id_q;

    // rst_n gates the arbiter so req_ready is 0 while reset is held.
    assign arb_en = (state_q == IDLE) && rst_n;
    assign accept = |gnt;

    alu_rr_arb u_arb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req_valid),
        .en_i   (arb_en),
        .gnt_o  (gnt)
    );

    alu_core #(.N(N)) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sel_i    (sel_q),
        .result_o (alu_result),
        .neg_o    (alu_neg),
        .zero_o   (alu_zero),
        .cry_o    (alu_cry),
        .of_o     (alu_of)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted requester's operation; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
            id_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= gnt[1] ? req_a1   : req_a0;
            b_q   <= gnt[1] ? req_b1   : req_b0;
            sel_q <= gnt[1] ? req_sel1 : req_sel0;
            id_q  <= gnt[1];
        end
    end

    // Error qualification of the raw ALU outputs.
    always_comb begin
        result_d = alu_result;
        neg_d    = alu_neg;
        zero_d   = alu_zero;
        cry_d    = alu_cry;
        of_d     = alu_of;
        err_d    = 1'b0;
        if (!op_is_legal(sel_q)) begin
            result_d = '0;
            neg_d    = 1'b0;
            zero_d   = 1'b0;
            cry_d    = 1'b0;
            of_d     = 1'b0;
            err_d    = 1'b1;
        end
`ifdef ALU_DIVZERO_TRAP_EN
        else if ((sel_q == OP_DIV) && (b_q == '0)) begin
            result_d = '0;
            neg_d    = 1'b0;
            zero_d   = 1'b1;
            cry_d    = 1'b0;
            of_d     = 1'b0;
            err_d    = 1'b1;
        end
`else
`endif
    end

    // Response registers load on leaving EXEC and hold through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            cry_q    <= 1'b0;
            of_q     <= 1'b0;
            err_q    <= 1'b0;
            rsp_id_q <= 1'b0;
        end else if (state_q == EXEC) begin
            result_q <= result_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            cry_q    <= cry_d;
            of_q     <= of_d;
            err_q    <= err_d;
            rsp_id_q <= id_q;
        end
    end

    assign req_ready  = gnt;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = result_q;
    assign rsp_neg    = neg_q;
    assign rsp_zero   = zero_q;
    assign rsp_cry    = cry_q;
    assign rsp_of     = of_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler (N = 4) with hand-computed expectations.
module tb_alu_scheduler;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_a0, req_b0, req_sel0;
    logic [3:0] req_a1, req_b1, req_sel1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_neg, rsp_zero, rsp_cry, rsp_of, rsp_err;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_scheduler #(.N(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_sel0   (req_sel0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_sel1   (req_sel1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_neg    (rsp_neg),
        .rsp_zero   (rsp_zero),
        .rsp_cry    (rsp_cry),
        .rsp_of     (rsp_of),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [7:0] res,
                           input logic neg, input logic zero, input logic cry,
                           input logic ovf, input logic err);
        chk1({tag, ".valid"}, rsp_valid, 1'b1);
        chk1({tag, ".id"},    rsp_id, id);
        chk8({tag, ".res"},   rsp_result, res);
        chk1({tag, ".neg"},   rsp_neg, neg);
        chk1({tag, ".zero"},  rsp_zero, zero);
        chk1({tag, ".cry"},   rsp_cry, cry);
        chk1({tag, ".of"},    rsp_of, ovf);
        chk1({tag, ".err"},   rsp_err, err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk2({tag, ".ready"}, req_ready, 2'b00);
        chk1({tag, ".valid"}, rsp_valid, 1'b0);
        chk1({tag, ".busy"},  busy, 1'b0);
        chk1({tag, ".id"},    rsp_id, 1'b0);
        chk8({tag, ".res"},   rsp_result, 8'h00);
        chk1({tag, ".neg"},   rsp_neg, 1'b0);
        chk1({tag, ".zero"},  rsp_zero, 1'b0);
        chk1({tag, ".cry"},   rsp_cry, 1'b0);
        chk1({tag, ".of"},    rsp_of, 1'b0);
        chk1({tag, ".err"},   rsp_err, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        req_a0 = 4'b0101; req_b0 = 4'b0011; req_sel0 = 4'b1001;
        req_a1 = 4'b1010; req_b1 = 4'b0111; req_sel1 = 4'b0100;

        // Reset state with both requesters valid.
        #12;
        chk_all_zero("rst");

        // Simultaneous pair after reset: req0 first.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk2("pair1.gnt", req_ready, 2'b01);
        step();
        req_a0 = 4'b0010; req_b0 = 4'b0011; req_sel0 = 4'b0010;
        chk1("pair1.exec_busy", busy, 1'b1);
        chk1("pair1.exec_valid", rsp_valid, 1'b0);
        chk2("pair1.exec_ready", req_ready, 2'b00);
        step();
        chk_rsp("pair1.add", 1'b0, 8'b0000_1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk1("pair2.idle_valid", rsp_valid, 1'b0);
        chk2("pair2.gnt", req_ready, 2'b10);
        step();
        step();
        chk_rsp("pair2.xor", 1'b1, 8'b0000_1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk2("pair3.gnt", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        step();
        chk_rsp("pair3.and", 1'b0, 8'b0000_0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Mul, single requester, latency, input changes after accept, stall.
        req_a0 = 4'b1010; req_b0 = 4'b0111; req_sel0 = 4'b0000;
        req_valid = 2'b01;
        #1;
        chk2("mul.gnt", req_ready, 2'b01);
        step();
        req_a0 = 4'b1111; req_b0 = 4'b1111; req_sel0 = 4'b0101;
        req_valid = 2'b11;
        chk1("mul.lat1_valid", rsp_valid, 1'b0);
        step();
        chk_rsp("mul.lat2", 1'b0, 8'b0100_0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_rsp("hold", 1'b0, 8'b0100_0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk2("hold.ready", req_ready, 2'b00);
            chk1("hold.busy", busy, 1'b1);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk1("mul.done_valid", rsp_valid, 1'b0);
        chk1("mul.done_busy", busy, 1'b0);

        // Divide by zero from req1.
        req_a1 = 4'b1010; req_b1 = 4'b0000; req_sel1 = 4'b0110;
        req_valid = 2'b10;
        #1;
        chk2("div0.gnt", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        step();
`ifdef ALU_DIVZERO_TRAP_EN
        chk_rsp("div0.trap", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        chk_rsp("div0.raw", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Illegal opcode.
        req_a0 = 4'b1111; req_b0 = 4'b1111; req_sel0 = 4'b0101;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        chk_rsp("illegal", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset during EXEC (pointer is 1 beforehand).
        req_a0 = 4'b1111; req_b0 = 4'b0001; req_sel0 = 4'b1001;
        req_valid = 2'b01;
        step();
        req_valid = 2'b11;
        chk1("rstexec.busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rstexec.now");
        step();
        chk_all_zero("rstexec.held");
        req_valid = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk1("rstexec.no_rsp", rsp_valid, 1'b0);
            chk1("rstexec.idle", busy, 1'b0);
        end
        req_valid = 2'b11;
        #1;
        chk2("rstexec.gnt", req_ready, 2'b01);
        step();
        req_valid = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
